// File: rtl/ne_fp_sfr_pipe_w27s5.sv
// Two-stage pipelined right shifter with sign/zero fill and sticky collection for FP mantissa alignment.
// Optional feature macro NE_FP_SFR_STICKY_EN builds the sticky path; when undefined, out_sticky is constant 0.
module ne_fp_sfr_pipe_w27s5 #(
  parameter int BW_DATA = 27,
  parameter int BW_SF   = 5,
  parameter bit SIGNED  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BW_DATA-1:0] in_a,
  input  logic [BW_SF-1:0]   in_s,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BW_DATA-1:0] out_z,
  output logic               out_sticky
);

  // One power-of-two shift step; steps at or beyond the width leave only fill bits.
  function automatic logic [BW_DATA-1:0] step_data(input logic [BW_DATA-1:0] d,
                                                   input logic fill, input int amt);
    logic [BW_DATA-1:0] ones;
    ones = {BW_DATA{1'b1}};
    if (amt >= BW_DATA) step_data = {BW_DATA{fill}};
    else                step_data = (d >> amt) | ({BW_DATA{fill}} & ~(ones >> amt));
  endfunction

`ifdef NE_FP_SFR_STICKY_EN
  function automatic logic step_sticky(input logic [BW_DATA-1:0] d, input int amt);
    logic [BW_DATA-1:0] ones;
    ones = {BW_DATA{1'b1}};
    if (amt >= BW_DATA) step_sticky = |d;
    else                step_sticky = |(d & ~(ones << amt));
  endfunction
`endif

  logic               s1_valid_r, s2_valid_r;
  logic               s1_adv_s, s2_adv_s;
  logic [BW_DATA-1:0] s1_data_s, s1_data_r, s2_data_s, out_z_r;
  logic               s1_fill_s, s1_fill_r;
  logic [2:0]         s1_res_s, s1_res_r;
`ifdef NE_FP_SFR_STICKY_EN
  logic               s1_stk_s, s1_stk_r, s2_stk_s, out_sticky_r;
`endif

  assign s2_adv_s  = !s2_valid_r || out_ready;
  assign s1_adv_s  = !s1_valid_r || s2_adv_s;
  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_r;
  assign out_z     = out_z_r;

  // Stage 1 datapath: coarse steps of 8/16/32 plus fill and residual extraction.
  always_comb begin
    if (SIGNED) s1_fill_s = in_a[BW_DATA-1];
    else        s1_fill_s = 1'b0;
    s1_data_s = in_a;
    s1_res_s  = 3'b000;
`ifdef NE_FP_SFR_STICKY_EN
    s1_stk_s  = 1'b0;
`endif
    for (int k = 0; k < 3 && k < BW_SF; k++) s1_res_s[k] = in_s[k];
    for (int k = 3; k < BW_SF; k++) begin
      if (in_s[k]) begin
`ifdef NE_FP_SFR_STICKY_EN
        s1_stk_s  = s1_stk_s | step_sticky(s1_data_s, 1 << k);
`endif
        s1_data_s = step_data(s1_data_s, s1_fill_s, 1 << k);
      end else begin
        s1_data_s = s1_data_s;
      end
    end
  end

  // Stage 2 datapath: residual 1/2/4 steps on the registered partial result.
  always_comb begin
    s2_data_s = s1_data_r;
`ifdef NE_FP_SFR_STICKY_EN
    s2_stk_s  = s1_stk_r;
`endif
    for (int k = 0; k < 3; k++) begin
      if (s1_res_r[k]) begin
`ifdef NE_FP_SFR_STICKY_EN
        s2_stk_s  = s2_stk_s | step_sticky(s2_data_s, 1 << k);
`endif
        s2_data_s = step_data(s2_data_s, s1_fill_r, 1 << k);
      end else begin
        s2_data_s = s2_data_s;
      end
    end
  end

  // Stage 1 registers; payload only loads when a valid operand is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {BW_DATA{1'b0}};
      s1_fill_r  <= 1'b0;
      s1_res_r   <= 3'b000;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_data_r <= s1_data_s;
        s1_fill_r <= s1_fill_s;
        s1_res_r  <= s1_res_s;
      end
    end
  end

  // Stage 2 (output) registers; held stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      out_z_r    <= {BW_DATA{1'b0}};
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) out_z_r <= s2_data_s;
    end
  end

`ifdef NE_FP_SFR_STICKY_EN
  // Sticky registers follow the same load enables as the data they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_stk_r     <= 1'b0;
      out_sticky_r <= 1'b0;
    end else begin
      if (s1_adv_s && in_valid)   s1_stk_r     <= s1_stk_s;
      if (s2_adv_s && s1_valid_r) out_sticky_r <= s2_stk_s;
    end
  end
  assign out_sticky = out_sticky_r;
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_ne_fp_sfr_pipe_w27s5.sv
// Scoreboard bench: two instances (zero fill and sign fill) share stimulus; a monitor pops expectations.
module tb_ne_fp_sfr_pipe_w27s5;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [26:0] in_a;
  logic [4:0]  in_s;
  logic        rdy0, rdy1, ov0, ov1, st0, st1;
  logic [26:0] z0, z1;
  int          n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct {
    logic [26:0] z0;
    logic [26:0] z1;
    logic        stk;
    int          acc;
    bit          chk_lat;
    bit          consec;
  } exp_t;
  exp_t sb[$];

  logic [26:0] va[16], vz0[16], vz1[16];
  logic [4:0]  vs[16];
  logic        vk[16];

  ne_fp_sfr_pipe_w27s5 #(.BW_DATA(27), .BW_SF(5), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_a(in_a), .in_s(in_s),
    .out_valid(ov0), .out_ready(out_ready), .out_z(z0), .out_sticky(st0));
  ne_fp_sfr_pipe_w27s5 #(.BW_DATA(27), .BW_SF(5), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_s(in_s),
    .out_valid(ov1), .out_ready(out_ready), .out_z(z1), .out_sticky(st1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input int i, input bit lat, input bit consec, input int exp_rdy);
    int   n;
    exp_t e;
    n = 0;
    in_valid = 1'b1; in_a = va[i]; in_s = vs[i];
    @(negedge clk);
    if (exp_rdy >= 0) check("in_ready", {31'd0, rdy0}, exp_rdy);
    while (!rdy0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: operand %0d not accepted after %0d cycles", i, n);
    end else begin
      e.z0 = vz0[i]; e.z1 = vz1[i];
`ifdef NE_FP_SFR_STICKY_EN
      e.stk = vk[i];
`else
      e.stk = 1'b0;
`endif
      e.acc = cyc; e.chk_lat = lat; e.consec = consec;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compares every delivered result and checks hold-stability during stalls.
  initial begin
    exp_t        e;
    logic [26:0] hz;
    bit          hv;
    int          last_pop;
    hv = 1'b0; hz = 27'd0; last_pop = -10;
    forever begin
      @(negedge clk);
      if (rst) begin
        hv = 1'b0;
      end else begin
        if (ov0 && !out_ready) begin
          if (hv) check("stall_hold", {5'd0, z0}, {5'd0, hz});
          hv = 1'b1; hz = z0;
        end else begin
          hv = 1'b0;
        end
        if (ov0 && out_ready) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_output: got z=%h with no pending operand", z0);
          end else begin
            e = sb.pop_front();
            check("z_zero_fill", {5'd0, z0}, {5'd0, e.z0});
            check("z_sign_fill", {5'd0, z1}, {5'd0, e.z1});
            check("sticky_zero_fill", {31'd0, st0}, {31'd0, e.stk});
            check("sticky_sign_fill", {31'd0, st1}, {31'd0, e.stk});
            check("valid_sign_inst", {31'd0, ov1}, 32'd1);
            if (e.chk_lat) check("latency", cyc - e.acc, 32'd2);
            if (e.consec) check("consecutive", cyc, last_pop + 1);
            last_pop = cyc;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    va  = '{27'h4000001, 27'h4000000, 27'h4000000, 27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFF,
            27'h0000100, 27'h00000FF, 27'h1234567, 27'h5555555, 27'h0000008, 27'h6000000,
            27'h4000000, 27'h0ABCDEF, 27'h7FFFFFE, 27'h0000001};
    vs  = '{5'd1, 5'd4, 5'd31, 5'd27, 5'd31, 5'd0, 5'd8, 5'd8,
            5'd12, 5'd3, 5'd3, 5'd26, 5'd16, 5'd20, 5'd1, 5'd26};
    vz0 = '{27'h2000000, 27'h0400000, 27'h0000000, 27'h0000000, 27'h0000000, 27'h7FFFFFF,
            27'h0000001, 27'h0000000, 27'h0001234, 27'h0AAAAAA, 27'h0000001, 27'h0000001,
            27'h0000400, 27'h000000A, 27'h3FFFFFF, 27'h0000000};
    vz1 = '{27'h6000000, 27'h7C00000, 27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFF,
            27'h0000001, 27'h0000000, 27'h0001234, 27'h7AAAAAA, 27'h0000001, 27'h7FFFFFF,
            27'h7FFFC00, 27'h000000A, 27'h7FFFFFF, 27'h0000000};
    vk  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
            1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_a = 27'd0; in_s = 5'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'd0, ov0}, 32'd0);
    check("reset_out_z", {5'd0, z0}, 32'd0);
    check("reset_sticky", {31'd0, st0}, 32'd0);
    check("reset_in_ready", {31'd0, rdy0}, 32'd1);
    @(posedge clk); #1;

    // Isolated operands with latency check.
    for (int i = 0; i < 6; i++) begin
      send(i, 1'b1, 1'b0, 1);
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-to-back stream, ready held high.
    for (int i = 6; i < 14; i++) send(i, 1'b0, (i > 6), 1);
    repeat (6) @(posedge clk);
    #1;

    // Backpressure: three operands against a 4-cycle stall.
    out_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        send(14, 1'b0, 1'b0, 1);
        send(15, 1'b0, 1'b0, 1);
        send(0, 1'b0, 1'b0, 0);
      end
    join
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);
    @(posedge clk); #1;

    // Reset with two operands in flight; nothing stale may emerge afterwards.
    out_ready = 1'b0;
    send(1, 1'b0, 1'b0, 1);
    send(2, 1'b0, 1'b0, 1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", {31'd0, ov0}, 32'd0);
    check("midreset_out_z", {5'd0, z0}, 32'd0);
    check("midreset_in_ready", {31'd0, rdy0}, 32'd1);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ne_fp_sfr_pipe_w27s5.md
Name: ne_fp_sfr_pipe_w27s5

Overview:
- Pipelined right shifter for FP mantissa alignment: data shifted toward LSB by a variable amount, with sign/zero fill and sticky collection of the discarded bits.
- Counterpart to the combinational left-shift normalizer in the ne_fp datapath; feeds the adder's aligned-operand path.
- Two register stages with valid/ready flow control, throughput one operand per cycle.

Parameters:
- BW_DATA, 27, data width (>=2).
- BW_SF, 5, shift-amount width (1..6).
- SIGNED, 0, 1 = arithmetic fill with a[BW_DATA-1]; 0 = zero fill.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept input this cycle.
- in_a  in  BW_DATA  data to shift.
- in_s  in  BW_SF  right-shift amount, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_z  out  BW_DATA  shifted result.
- out_sticky  out  1  OR of all bits shifted out (see Optional Feature).

Behaviour:
- Function: out_z = in_a >> in_s, fill = sign bit if SIGNED else 0. in_s >= BW_DATA gives out_z = all fill bits.
- Sticky: OR of in_a[min(in_s,BW_DATA)-1:0]. in_s=0 gives 0. Shifted-out bits come from original in_a, not the fill.
- Stage 1 (s1): applies shift bits in_s[BW_SF-1:3] (the 8/16/32 steps, only those < BW_SF). Registers partial data, partial sticky, residual in_s[2:0], and the fill bit.
- Stage 2 (s2): applies residual bits [2:0] (1/2/4 steps) and ORs in its discarded bits. Registers out_z and out_sticky.
- Latency: 2 cycles from an in_valid&&in_ready edge to out_valid=1.
- Handshake:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = s1 advances (combinational from out_ready; no skid buffer).
  - Transfer occurs only on valid&&ready. out_z and out_sticky hold stable while out_valid && !out_ready.
- Backpressure: at most 2 operands in flight. in_ready drops only when both stages are full and out_ready=0.
- Simultaneous events: a full pipe with out_ready=1 accepts a new input the same cycle; no bubble.
- Reset: s1_valid=0, s2_valid=0, out_z=0, out_sticky=0, in_ready=1 in the first cycle after reset. In-flight operands are discarded, not flushed out. Reset overrides any same-cycle handshake.
- Empty stages hold their data; data registers need not update when valid=0.
- Width rules: shift steps >= BW_DATA produce all fill bits and OR the whole stage input into sticky.

Optional Feature:
- Macro NE_FP_SFR_STICKY_EN.
- Defined: sticky logic and registers built as described in Behaviour.
- Undefined: out_sticky tied to 1'b0, no sticky registers. Port list unchanged; out_z and timing are identical.

Test Plan:
- SIGNED=0, in_a=27'h4000001, in_s=1 -> out_z=27'h2000000, out_sticky=1, out_valid 2 cycles after accept.
- SIGNED=1, in_a=27'h4000000, in_s=4 -> out_z=27'h7C00000, out_sticky=0. Same with in_s=31 -> out_z=27'h7FFFFFF.
- SIGNED=0, in_a=27'h7FFFFFF, in_s=27 and in_s=31 -> out_z=0, out_sticky=1. in_s=0 -> out_z=27'h7FFFFFF, sticky=0.
- Back-to-back: 8 operands, one per cycle, out_ready=1 -> 8 results on consecutive cycles, in order, in_ready held 1.
- Backpressure: out_ready=0 for 4 cycles while feeding 3 operands -> in_ready falls after 2 accepted. out_z stable while stalled. All 3 results delivered in order after out_ready=1, none lost or duplicated.
- Reset mid-operation: 2 operands in flight, assert rst for 1 cycle -> out_valid=0, out_z=0, in_ready=1 next cycle. No stale result emitted later.
